// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
//
// Purpose: sequencer state encoding, UART data width and the baud-select
//          codes shared with the baud controller.
// Ports:   none (package).
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } tx_state_t;

    localparam logic [2:0] BAUD_SEL_1200   = 3'b000;
    localparam logic [2:0] BAUD_SEL_2400   = 3'b001;
    localparam logic [2:0] BAUD_SEL_4800   = 3'b010;
    localparam logic [2:0] BAUD_SEL_9600   = 3'b011;
    localparam logic [2:0] BAUD_SEL_19200  = 3'b100;
    localparam logic [2:0] BAUD_SEL_38400  = 3'b101;
    localparam logic [2:0] BAUD_SEL_57600  = 3'b110;
    localparam logic [2:0] BAUD_SEL_115200 = 3'b111;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - DEPTH x 8 synchronous-write, asynchronous-read array
//
// Purpose: byte storage for uart_tx_fifo. Contents are not reset.
// Ports:
//   i_clk      - clock, rising edge
//   i_wr_en    - write strobe
//   i_wr_addr  - write address
//   i_wr_data  - write byte
//   i_rd_addr  - read address
//   o_rd_data  - combinational read byte
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                   i_clk,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic [UART_DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    output logic [UART_DATA_W-1:0] o_rd_data
);

    logic [UART_DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and write sequencer feeding uart_transmitter
//
// Purpose: queues host bytes and hands them one at a time to the transmitter,
//          holding Tx_WR until TX_BUSY acknowledges and waiting for TX_BUSY
//          to drop before the next byte.
// Optional: define UART_TX_FIFO_OVF_EN to add the sticky ovf flag / ovf_clr.
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous active-high reset
//   wr_data  - byte to enqueue
//   wr_en    - enqueue strobe, ignored while full
//   full     - FIFO holds DEPTH bytes
//   empty    - FIFO holds no bytes
//   count    - occupancy 0..DEPTH
//   Tx_DATA  - byte presented to the transmitter
//   Tx_WR    - write request level to the transmitter
//   TX_BUSY  - transmitter busy flag
//   idle     - FIFO empty and sequencer idle
//   ovf      - (optional) sticky dropped-write flag
//   ovf_clr  - (optional) clears ovf; a same-cycle set wins
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic [UART_DATA_W-1:0] Tx_DATA,
    output logic                   Tx_WR,
    input  logic                   TX_BUSY,
    output logic                   idle
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                   ovf,
    input  logic                   ovf_clr
`endif
);

    generate
        if ((DEPTH < 2) || (DEPTH != (1 << ADDR_W))) begin : g_bad_param
            $error("uart_tx_fifo: DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
        end
    endgenerate

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]        r_wr_ptr;
    logic [ADDR_W:0]        r_rd_ptr;
    logic [ADDR_W:0]        r_count;
    logic                   r_full;
    logic                   r_empty;
    logic [ADDR_W:0]        w_wr_ptr_nxt;
    logic [ADDR_W:0]        w_rd_ptr_nxt;
    logic [ADDR_W:0]        w_count_nxt;
    logic                   w_full_nxt;
    logic                   w_empty_nxt;
    logic                   w_push;
    logic                   w_pop;
    logic [UART_DATA_W-1:0] w_mem_rd;

    tx_state_t              r_state;
    logic                   r_tx_wr;
    logic [UART_DATA_W-1:0] r_tx_data;
    logic                   r_idle;
    logic                   w_state_idle_nxt;

    // full is the registered flag, so a push in the same cycle as a pop
    // from a full FIFO is still refused.
    assign w_push = wr_en && !r_full;
    assign w_pop  = (r_state == S_IDLE) && !r_empty && !TX_BUSY;

    assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    assign w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    // Same slot, different lap: writer is a full buffer ahead of the reader.
    assign w_full_nxt   = (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                          (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk     (clock),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr[ADDR_W-1:0]),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rd_ptr[ADDR_W-1:0]),
        .o_rd_data (w_mem_rd)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= w_full_nxt;
            r_empty  <= w_empty_nxt;
        end
    end

    // Whether the sequencer will sit in S_IDLE after this edge; feeds the
    // registered idle output so it agrees with the state after the edge.
    always_comb begin
        w_state_idle_nxt = 1'b0;
        case (r_state)
            S_IDLE:  w_state_idle_nxt = !w_pop;
            S_REQ:   w_state_idle_nxt = 1'b0;
            S_WAIT:  w_state_idle_nxt = !TX_BUSY;
            default: w_state_idle_nxt = 1'b1;
        endcase
    end

    // Tx_WR is held as a level from the pop until TX_BUSY acknowledges, so
    // the handshake does not depend on the transmitter's sampling latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tx_wr   <= 1'b0;
            r_tx_data <= '0;
            r_idle    <= 1'b1;
        end else begin
            r_idle <= w_empty_nxt && w_state_idle_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state   <= S_REQ;
                        r_tx_wr   <= 1'b1;
                        r_tx_data <= w_mem_rd;
                    end
                end
                S_REQ: begin
                    if (TX_BUSY) begin
                        r_state <= S_WAIT;
                        r_tx_wr <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!TX_BUSY) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx_wr <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (wr_en && r_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

    assign full    = r_full;
    assign empty   = r_empty;
    assign count   = r_count;
    assign Tx_DATA = r_tx_data;
    assign Tx_WR   = r_tx_wr;
    assign idle    = r_idle;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic [7:0] Tx_DATA;
    logic       Tx_WR;
    logic       TX_BUSY;
    logic       idle;
`ifdef UART_TX_FIFO_OVF_EN
    logic       ovf;
    logic       ovf_clr;
`endif

    always #5 clock = ~clock;

    uart_tx_fifo #(
        .DEPTH  (8),
        .ADDR_W (3)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .Tx_DATA (Tx_DATA),
        .Tx_WR   (Tx_WR),
        .TX_BUSY (TX_BUSY),
        .idle    (idle)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Transmitter model: busy rises 3 cycles after seeing Tx_WR and stays
    // high for busy_len cycles. Acts on the falling edge.
    logic       model_en = 1'b0;
    int         busy_len = 50;
    int         m_st     = 0;
    int         m_cnt    = 0;
    int         rises    = 0;
    logic       prev_wr  = 1'b0;
    logic [7:0] cap_q[$];
    logic [3:0] cnt_q[$];

    always @(negedge clock) begin
        if (Tx_WR === 1'b1 && prev_wr !== 1'b1) rises++;
        prev_wr = Tx_WR;
        if (!model_en) begin
            m_st = 0;
        end else begin
            case (m_st)
                0: if (Tx_WR === 1'b1) begin
                    cap_q.push_back(Tx_DATA);
                    cnt_q.push_back(count);
                    m_cnt = 1;
                    m_st  = 1;
                end
                1: if (m_cnt == 3) begin
                    TX_BUSY = 1'b1;
                    m_cnt   = 1;
                    m_st    = 2;
                end else begin
                    m_cnt++;
                end
                default: if (m_cnt >= busy_len) begin
                    TX_BUSY = 1'b0;
                    m_st    = 0;
                end else begin
                    m_cnt++;
                end
            endcase
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input string tag, input logic lvl, input int bound);
        int n = 0;
        while (TX_BUSY !== lvl && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < bound), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        while (!(idle === 1'b1 && TX_BUSY === 1'b0 && m_st == 0) && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < bound), 32'd1);
    endtask

    initial begin
        logic       q_ok;
        logic [7:0] exp_q[$];
        int         n;
        int         maxc;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        TX_BUSY = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;

        // Reset values, then 100 quiet cycles.
        chk("rst_empty",  32'(empty),   32'd1);
        chk("rst_full",   32'(full),    32'd0);
        chk("rst_count",  32'(count),   32'd0);
        chk("rst_txwr",   32'(Tx_WR),   32'd0);
        chk("rst_idle",   32'(idle),    32'd1);
        chk("rst_txdata", 32'(Tx_DATA), 32'h00);
        q_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!(empty === 1'b1 && full === 1'b0 && count === 4'd0 &&
                  Tx_WR === 1'b0 && idle === 1'b1 && Tx_DATA === 8'h00)) q_ok = 1'b0;
        end
        chk("quiet_100", 32'(q_ok), 32'd1);

        // Single byte through the transmitter model.
        model_en = 1'b1;
        busy_len = 50;
        cap_q.delete();
        rises = 0;
        wr_data = 8'hDD;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("t2_count_push", 32'(count), 32'd1);
        chk("t2_txwr_early", 32'(Tx_WR), 32'd0);
        chk("t2_idle_busy",  32'(idle),  32'd0);
        tick();
        chk("t2_txwr_rise",  32'(Tx_WR),   32'd1);
        chk("t2_txdata",     32'(Tx_DATA), 32'hDD);
        chk("t2_empty_pop",  32'(empty),   32'd1);
        wait_busy("t2_busy_rise_timeout", 1'b1, 20);
        tick();
        chk("t2_txwr_drop", 32'(Tx_WR), 32'd0);
        wait_busy("t2_busy_fall_timeout", 1'b0, 80);
        chk("t2_idle_in_wait", 32'(idle), 32'd0);
        tick();
        chk("t2_idle_after", 32'(idle),        32'd1);
        chk("t2_data_hold",  32'(Tx_DATA),     32'hDD);
        chk("t2_nbytes",     32'(cap_q.size()), 32'd1);
        chk("t2_rises",      32'(rises),       32'd1);

        // Three bytes queued behind a busy transmitter, then drained.
        model_en = 1'b0;
        TX_BUSY  = 1'b1;
        cap_q.delete();
        cnt_q.delete();
        rises = 0;
        wr_en = 1'b1;
        wr_data = 8'hDD; tick();
        wr_data = 8'h1A; tick();
        wr_data = 8'h55; tick();
        wr_en = 1'b0;
        chk("t3_count3", 32'(count), 32'd3);
        chk("t3_no_pop", 32'(Tx_WR), 32'd0);
        TX_BUSY  = 1'b0;
        model_en = 1'b1;
        wait_idle("t3_drain_timeout", 400);
        chk("t3_nbytes", 32'(cap_q.size()), 32'd3);
        chk("t3_b0", 32'(cap_q[0]), 32'hDD);
        chk("t3_b1", 32'(cap_q[1]), 32'h1A);
        chk("t3_b2", 32'(cap_q[2]), 32'h55);
        chk("t3_c0", 32'(cnt_q[0]), 32'd2);
        chk("t3_c1", 32'(cnt_q[1]), 32'd1);
        chk("t3_c2", 32'(cnt_q[2]), 32'd0);
        chk("t3_rises", 32'(rises), 32'd3);

        // Fill to full with busy held, drop the 9th byte, then drain.
        model_en = 1'b0;
        TX_BUSY  = 1'b1;
        cap_q.delete();
        rises = 0;
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("t4_full",  32'(full),  32'd1);
        chk("t4_count", 32'(count), 32'd8);
        chk("t4_empty", 32'(empty), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("t4_ovf_pre", 32'(ovf), 32'd0);
`endif
        wr_data = 8'h99;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("t4_count_drop", 32'(count), 32'd8);
        chk("t4_full_drop",  32'(full),  32'd1);
`ifdef UART_TX_FIFO_OVF_EN
        chk("t4_ovf_set", 32'(ovf), 32'd1);
        tick();
        chk("t4_ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        chk("t4_ovf_clr", 32'(ovf), 32'd0);
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("t4_ovf_set_wins", 32'(ovf), 32'd1);
        tick();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr2", 32'(ovf), 32'd0);
`endif
        TX_BUSY  = 1'b0;
        model_en = 1'b1;
        wait_idle("t4_drain_timeout", 600);
        chk("t4_nbytes", 32'(cap_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_b%0d", i), 32'(cap_q[i]), 32'(8'h10 + i));
        end
        chk("t4_rises", 32'(rises), 32'd8);

        // Steady flow across pointer wrap with a short busy pulse.
        busy_len = 1;
        cap_q.delete();
        exp_q.delete();
        n    = 0;
        maxc = 0;
        for (int c = 0; c < 20; c++) begin
            if (count < 4'd4) begin
                wr_data = 8'(8'hA0 + n);
                wr_en   = 1'b1;
                exp_q.push_back(8'(8'hA0 + n));
                n++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            if (int'(count) > maxc) maxc = int'(count);
        end
        wr_en = 1'b0;
        wait_idle("t5_drain_timeout", 400);
        chk("t5_nbytes", 32'(cap_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("t5_b%0d", i), 32'(cap_q[i]), 32'(exp_q[i]));
        end
        chk("t5_max_count", 32'(maxc <= 8), 32'd1);
        chk("t5_count_end", 32'(count), 32'd0);

        // Reset while in S_WAIT with three bytes queued.
        busy_len = 50;
        cap_q.delete();
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_en = 1'b0;
        chk("t6_count_q", 32'(count), 32'd3);
        wait_busy("t6_busy_timeout", 1'b1, 20);
        tick();
        chk("t6_in_wait", 32'(Tx_WR), 32'd0);
        reset    = 1'b1;
        model_en = 1'b0;
        TX_BUSY  = 1'b0;
        #1;
        chk("t6_async_count", 32'(count),   32'd0);
        chk("t6_async_empty", 32'(empty),   32'd1);
        chk("t6_async_full",  32'(full),    32'd0);
        chk("t6_async_txwr",  32'(Tx_WR),   32'd0);
        chk("t6_async_idle",  32'(idle),    32'd1);
        chk("t6_async_data",  32'(Tx_DATA), 32'h00);
        tick();
        reset = 1'b0;
        rises = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_no_txwr", 32'(rises), 32'd0);
        chk("t6_idle",    32'(idle),  32'd1);
        chk("t6_count",   32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and write sequencer directly upstream of uart_transmitter.
- Accepts bytes from a host at clock rate and presents them one at a time on Tx_DATA/Tx_WR.
- Paces each byte on the transmitter's TX_BUSY, so a host can queue a multi-byte message without tracking baud timing.
- Instantiated between host logic and uart_transmitter; TX_EN is driven outside this block.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of two and at least 2.
- ADDR_W, 3, log2(DEPTH); sets the pointer width.

Ports:
- clock  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-high reset.
- wr_data  input  8  byte to enqueue.
- wr_en  input  1  enqueue strobe; accepted only when full=0.
- full  output  1  FIFO holds DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- Tx_DATA  output  8  byte presented to the transmitter.
- Tx_WR  output  1  write request to the transmitter.
- TX_BUSY  input  1  transmitter busy flag.
- idle  output  1  FIFO empty and sequencer in S_IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers and count cleared.
  - full=0, empty=1, count=0.
  - Tx_DATA=8'h00, Tx_WR=0, idle=1, state=S_IDLE.
  - Storage array is not cleared.
- Storage and pointers:
  - Circular buffer with wr_ptr/rd_ptr of ADDR_W+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap naturally modulo 2*DEPTH.
  - full when the pointer MSBs differ and the lower bits are equal; empty when the pointers are equal.
  - count = wr_ptr - rd_ptr, computed modulo 2^(ADDR_W+1).
  - Flags and count are registered and update on the edge that changes the pointers.
- Push: wr_en=1 and full=0 writes wr_data at wr_ptr and increments wr_ptr. wr_en while full is silently dropped; no state changes.
- Pop: occurs only on the S_IDLE->S_REQ transition. Tx_DATA is loaded from mem[rd_ptr] and rd_ptr increments on the same edge.
- Simultaneous push and pop: both take effect and count is unchanged. A push into a full FIFO is still refused in the cycle a pop occurs; full is evaluated before the edge.
- Sequencer states:
  - S_IDLE:
    - Tx_WR=0.
    - If empty=0 and TX_BUSY=0: pop, go to S_REQ.
    - Else stay.
  - S_REQ:
    - Tx_WR=1 and Tx_DATA held stable.
    - Stay until TX_BUSY=1, then go to S_WAIT with Tx_WR=0 on the next cycle.
    - Tx_WR is a level held until the transmitter acknowledges via busy, never a single-cycle pulse; this keeps the handshake independent of the transmitter's sampling latency.
  - S_WAIT:
    - Tx_WR=0.
    - Stay while TX_BUSY=1; on TX_BUSY=0 go to S_IDLE.
- Latency and throughput:
  - First byte: Tx_WR rises 2 cycles after the accepting wr_en edge (1 cycle for the push, 1 for the pop).
  - Back-to-back bytes: at least 1 idle cycle between TX_BUSY falling and the next Tx_WR rising.
- If TX_BUSY is already 1 while in S_IDLE (foreign writer or TX still finishing), no pop occurs.
- Tx_DATA keeps the last popped byte until the next pop.
- A reset mid-frame abandons the in-flight byte and all queued bytes; the transmitter is reset by the same net.
- idle is registered and equals (empty && state==S_IDLE) after the edge.

Optional Feature:
- Macro: UART_TX_FIFO_OVF_EN.
- Defined:
  - Adds output ovf (1 bit, reset 0) and input ovf_clr (1 bit).
  - ovf is set on any wr_en while full=1 and stays set until ovf_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Undefined: neither port exists; dropped writes are silent.

Decomposition:
- Package uart_pkg:
  - State encoding: S_IDLE=2'd0, S_REQ=2'd1, S_WAIT=2'd2.
  - UART_DATA_W=8.
  - Baud-select code constants 3'b000..3'b111 shared with the baud controller.
- One sub-module, uart_fifo_mem: synchronous-write, asynchronous-read DEPTH x 8 array.
- Pointer, flag and sequencer logic stay in uart_tx_fifo.

Test Plan:
- Reset then no stimulus -> empty=1, full=0, count=0, Tx_WR=0, idle=1, Tx_DATA=8'h00 for 100 cycles.
- Push 8'hDD with a TX model (busy rises 3 cycles after Tx_WR, lasts 50 cycles) -> Tx_WR rises 2 cycles after push, Tx_DATA=8'hDD, Tx_WR drops the cycle after busy, idle=1 after busy falls.
- Push 8'hDD, 8'h1A, 8'h55 back-to-back -> TX sees DD, 1A, 55 in order, exactly one Tx_WR assertion per byte, count walks 3->2->1->0.
- Hold TX_BUSY=1, push 9 bytes -> full=1 at count=8, 9th byte dropped, count stays 8; release busy -> the 8 original bytes emerge in order. With UART_TX_FIFO_OVF_EN defined, ovf=1 until ovf_clr.
- Keep FIFO half full while the TX model pops, pushing every cycle for 20 cycles across pointer wrap -> no byte lost or duplicated, count never exceeds 8.
- Assert reset while in S_WAIT with 3 bytes queued -> all outputs return to reset values asynchronously; after release no Tx_WR until a new push.
